// File: rtl/wifi_tx_interleaver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wifi_tx_interleaver_pkg
// Description : Shared WIFI TX constants: coded bits per OFDM symbol for the
//               supported modulations and the 802.11a interleaver row count.
// Revision    : 1.0 - initial release
// ============================================================================
package wifi_tx_interleaver_pkg;

    // Coded bits per OFDM symbol
    localparam int c_n_cbps_bpsk = 48;
    localparam int c_n_cbps_qpsk = 96;

    // The 802.11a block interleaver is always 16 rows deep; the column count
    // scales with N_CBPS.
    localparam int c_intlv_rows  = 16;
    localparam int c_row_w       = 4;

endpackage : wifi_tx_interleaver_pkg
`default_nettype wire

// File: rtl/wifi_intlv_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : wifi_intlv_addr_gen
// Description : Incremental write-address generator for the 802.11a first
//               permutation. For input index k it produces
//               i = COLS*(k mod 16) + floor(k/16) without a multiplier by
//               walking rows (step COLS) and restarting at col+1 on row wrap.
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   i_advance in   accept the current bit, step to the next index
//   o_addr    out  write address for the current index k
//   o_last    out  current index is k = N_CBPS-1
// Revision    : 1.0 - initial release
// ============================================================================
module wifi_intlv_addr_gen
    import wifi_tx_interleaver_pkg::*;
#(
    parameter int N_CBPS = c_n_cbps_bpsk
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_advance,
    output logic [$clog2(N_CBPS)-1:0] o_addr,
    output logic                      o_last
);

    localparam int COLS   = N_CBPS / c_intlv_rows;
    localparam int ADDR_W = $clog2(N_CBPS);
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

    logic [c_row_w-1:0] r_row;
    logic [COL_W-1:0]   r_col;
    logic [ADDR_W-1:0]  r_addr;

    logic w_row_wrap;
    logic w_last;

    assign w_row_wrap = (r_row == c_row_w'(c_intlv_rows - 1));
    assign w_last     = w_row_wrap && (r_col == COL_W'(COLS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row  <= '0;
            r_col  <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            if (w_last) begin
                // Symbol complete: next bit starts a new symbol at k=0
                r_row  <= '0;
                r_col  <= '0;
                r_addr <= '0;
            end else if (w_row_wrap) begin
                // Row 15 -> 0 moves to the next column; address restarts
                // at the top of that column.
                r_row  <= '0;
                r_col  <= r_col + COL_W'(1);
                r_addr <= ADDR_W'(r_col) + ADDR_W'(1);
            end else begin
                r_row  <= r_row + c_row_w'(1);
                r_addr <= r_addr + ADDR_W'(COLS);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = w_last;

endmodule : wifi_intlv_addr_gen
`default_nettype wire

// File: rtl/wifi_tx_interleaver.sv
`default_nettype none
// ============================================================================
// Module      : wifi_tx_interleaver
// Description : Bit-serial 802.11a BPSK block interleaver with a ping-pong
//               pair of N_CBPS-bit banks. Bits are written in permuted
//               order and read out sequentially, so one symbol streams to
//               the mapper while the next one is being written.
//   clk         in   clock (encoder output domain)
//   reset       in   synchronous active-high reset
//   valid_in    in   coded bit valid
//   data_in     in   coded bit
//   enable      in   downstream read enable
//   ready       out  current write bank is not full
//   valid_out   out  data_out holds an interleaved bit
//   data_out    out  interleaved bit (registered, holds when idle)
//   symbol_done out  pulse with the last bit of each symbol
//   overflow    out  sticky: a bit arrived while ready was low
// Revision    : 1.0 - initial release
// ============================================================================
module wifi_tx_interleaver
    import wifi_tx_interleaver_pkg::*;
#(
    parameter int N_CBPS = c_n_cbps_bpsk
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_in,
    input  logic data_in,
    input  logic enable,
    output logic ready,
    output logic valid_out,
    output logic data_out,
    output logic symbol_done,
    output logic overflow
);

    localparam int ADDR_W = $clog2(N_CBPS);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_stream = 1'b1;

    logic [N_CBPS-1:0] r_bank [2];
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [ADDR_W-1:0] r_rd_idx;
    logic [0:0]        r_state;
    logic              r_valid_out;
    logic              r_data_out;
    logic              r_symbol_done;
    logic              r_overflow;

    logic              w_ready;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_wr_last;
    logic              w_rd_fire;
    logic              w_rd_last;

    // wr_bank only ever points at a non-full bank while ready is high, so a
    // write can never land in the bank the reader is draining.
    assign w_ready   = ~r_full[r_wr_bank];
    assign w_wr_en   = valid_in && w_ready;
    assign w_rd_fire = r_full[r_rd_bank] && enable;
    assign w_rd_last = (r_rd_idx == ADDR_W'(N_CBPS - 1));

    wifi_intlv_addr_gen #(
        .N_CBPS (N_CBPS)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_wr_en),
        .o_addr    (w_wr_addr),
        .o_last    (w_wr_last)
    );

    // Bank storage carries no reset: contents are meaningless until the
    // matching full flag is set.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_bank[r_wr_bank][w_wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full        <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_rd_idx      <= '0;
            r_state       <= c_st_idle;
            r_valid_out   <= 1'b0;
            r_data_out    <= 1'b0;
            r_symbol_done <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (valid_in && !w_ready) begin
                r_overflow <= 1'b1;
            end

            // Write and read completions always hit different banks (one
            // is empty, the other full), so both flag updates can apply.
            if (w_rd_fire && w_rd_last) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            if (w_wr_en && w_wr_last) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end

            r_valid_out   <= w_rd_fire;
            r_symbol_done <= w_rd_fire && w_rd_last;
            if (w_rd_fire) begin
                r_data_out <= r_bank[r_rd_bank][r_rd_idx];
                r_rd_idx   <= w_rd_last ? '0 : r_rd_idx + ADDR_W'(1);
            end

            // Streaming is driven by the full flag directly, so a second
            // full bank is picked up back-to-back without a bubble.
            case (r_state)
                c_st_idle: begin
                    if (w_rd_fire) begin
                        r_state <= c_st_stream;
                    end
                end
                c_st_stream: begin
                    if (w_rd_fire && w_rd_last) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign ready       = w_ready;
    assign valid_out   = r_valid_out;
    assign data_out    = r_data_out;
    assign symbol_done = r_symbol_done;
    assign overflow    = r_overflow;

endmodule : wifi_tx_interleaver
`default_nettype wire

// File: tb/tb_wifi_tx_interleaver.sv
`default_nettype none
// ============================================================================
// Module      : tb_wifi_tx_interleaver
// Description : Self-checking bench for wifi_tx_interleaver. Expected output
//               bits are queued when a whole symbol has been driven and are
//               popped as the DUT presents valid_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wifi_tx_interleaver;

    localparam int N    = 48;
    localparam int COLS = N / 16;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic valid_in = 1'b0;
    logic data_in  = 1'b0;
    logic enable   = 1'b0;
    logic ready;
    logic valid_out;
    logic data_out;
    logic symbol_done;
    logic overflow;

    int       n_checks = 0;
    int       n_errors = 0;
    int       cyc      = 0;
    logic     en_q     = 1'b0;
    logic     sb[$];
    int       out_cnt  = 0;
    int       sd_cnt   = 0;
    int       first_vo = 0;
    int       last_vo  = 0;
    logic [N-1:0] sym_cap = '0;

    wifi_tx_interleaver #(
        .N_CBPS (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .enable      (enable),
        .ready       (ready),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .symbol_done (symbol_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        en_q <= enable;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            out_cnt = 0;
            sd_cnt  = 0;
        end else begin
            if (valid_out || symbol_done)
                check_value("symbol_done", symbol_done, valid_out && (out_cnt % N == N - 1));
            if (valid_out) begin
                check_value("valid_on_enable", en_q, 1'b1);
                if (sb.size() == 0) begin
                    check_value("unexpected_output", 1, 0);
                end else begin
                    check_value("data_out", data_out, sb.pop_front());
                end
                sym_cap[out_cnt % N] = data_out;
                if (out_cnt == 0) first_vo = cyc;
                last_vo = cyc;
                out_cnt++;
                if (symbol_done) sd_cnt++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    // Drives N contiguous bits; the reference permutation is applied and the
    // expected read order pushed once the whole symbol is in.
    task automatic send_symbol(input logic [N-1:0] bits, input bit toggle_en,
                               input bit chk_ready, output int start);
        logic [N-1:0] exp;
        exp   = '0;
        start = 0;
        for (int k = 0; k < N; k++) exp[COLS * (k % 16) + k / 16] = bits[k];
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            if (chk_ready) check_value("ready_high", ready, 1'b1);
            valid_in = 1'b1;
            data_in  = bits[k];
            if (toggle_en) enable = ~enable;
            if (k == 0) start = cyc;
        end
        for (int i = 0; i < N; i++) sb.push_back(exp[i]);
    endtask

    task automatic wait_outputs(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (out_cnt < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        if (out_cnt < n) check_value(tag, out_cnt, n);
    endtask

    function automatic int one_position();
        int pos;
        int ones;
        pos  = -1;
        ones = 0;
        for (int i = 0; i < N; i++) begin
            if (sym_cap[i]) begin
                pos = i;
                ones++;
            end
        end
        return (ones == 1) ? pos : -1;
    endfunction

    task automatic run_onehot(input int k, input int exp_pos);
        logic [N-1:0] b;
        int           start;
        b    = '0;
        b[k] = 1'b1;
        do_reset();
        enable = 1'b1;
        send_symbol(b, 1'b0, 1'b0, start);
        idle_cycle();
        wait_outputs(N, 200, $sformatf("timeout_onehot_k%0d", k));
        check_value($sformatf("onehot_k%0d_pos", k), one_position(), exp_pos);
        check_value($sformatf("onehot_k%0d_latency", k), first_vo - start, 49);
        check_value($sformatf("onehot_k%0d_sd", k), sd_cnt, 1);
    endtask

    initial begin
        logic [N-1:0] r;
        int           st;
        int           guard;

        // Reset state
        do_reset();
        check_value("rst_valid_out", valid_out, 1'b0);
        check_value("rst_data_out", data_out, 1'b0);
        check_value("rst_symbol_done", symbol_done, 1'b0);
        check_value("rst_overflow", overflow, 1'b0);
        check_value("rst_ready", ready, 1'b1);

        // Single-bit permutation probes
        run_onehot(1, 3);
        run_onehot(16, 1);
        run_onehot(47, 47);
        run_onehot(0, 0);

        // Three back-to-back random symbols, full throughput
        do_reset();
        enable = 1'b1;
        for (int s = 0; s < 3; s++) begin
            r = {$urandom, $urandom};
            send_symbol(r, 1'b0, 1'b1, st);
        end
        idle_cycle();
        wait_outputs(3 * N, 400, "timeout_b2b");
        check_value("b2b_contiguous", last_vo - first_vo, 3 * N - 1);
        check_value("b2b_sd_count", sd_cnt, 3);

        // Both banks fill with reader stalled; extra bit must be dropped
        do_reset();
        enable = 1'b0;
        for (int s = 0; s < 2; s++) begin
            r = {$urandom, $urandom};
            send_symbol(r, 1'b0, 1'b0, st);
        end
        idle_cycle();
        check_value("ovf_ready_low", ready, 1'b0);
        check_value("ovf_before", overflow, 1'b0);
        @(posedge clk); #1;
        valid_in = 1'b1;
        data_in  = 1'b1;
        idle_cycle();
        @(negedge clk);
        check_value("ovf_set", overflow, 1'b1);
        check_value("ovf_no_output", out_cnt, 0);
        @(posedge clk); #1;
        enable = 1'b1;
        wait_outputs(2 * N, 400, "timeout_ovf");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("ovf_sd_count", sd_cnt, 2);
        check_value("ovf_sticky", overflow, 1'b1);
        check_value("ovf_ready_back", ready, 1'b1);

        // Reader enable toggling every cycle
        do_reset();
        enable = 1'b0;
        r = {$urandom, $urandom};
        send_symbol(r, 1'b1, 1'b0, st);
        guard = 0;
        while (out_cnt < N && guard < 300) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            enable   = ~enable;
            guard++;
        end
        if (out_cnt < N) check_value("timeout_toggle", out_cnt, N);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("toggle_sd_count", sd_cnt, 1);

        // Reset mid-symbol while the previous symbol streams
        do_reset();
        enable = 1'b1;
        r = '1;
        send_symbol(r, 1'b0, 1'b0, st);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            valid_in = 1'b1;
            data_in  = 1'($urandom);
        end
        @(posedge clk); #1;
        reset    = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_value("midrst_valid_out", valid_out, 1'b0);
        check_value("midrst_data_out", data_out, 1'b0);
        check_value("midrst_symbol_done", symbol_done, 1'b0);
        check_value("midrst_overflow", overflow, 1'b0);
        check_value("midrst_ready", ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        r    = '0;
        r[5] = 1'b1;
        send_symbol(r, 1'b0, 1'b0, st);
        idle_cycle();
        wait_outputs(N, 200, "timeout_after_rst");
        check_value("after_rst_pos", one_position(), 15);
        check_value("after_rst_latency", first_vo - st, 49);
        check_value("after_rst_sd", sd_cnt, 1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_value("drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wifi_tx_interleaver
`default_nettype wire
